// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer and FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       fifo_wdata;
  logic                   fifo_wpush;
  logic                   fifo_wfull;

  modport master (
    output req_valid, req_last, req_data, fifo_wfull,
    input  req_ready, fifo_wdata, fifo_wpush
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_wfull,
    output req_ready, fifo_wdata, fifo_wpush
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among N_REQ producers
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fifo_wr_arbiter_if.slave         bus,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr, rr_d;
  logic [IDW-1:0] grant_d;
  logic           gv_d;
  logic [CW-1:0]  beat_cnt, beat_d;
  logic [IDW-1:0] pick;
  logic           any_req;
  logic           xfer;
  logic           release_grant;

  // Scan from the highest offset down so the nearest set bit after rr_ptr wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        pick    = IDW'((int'(rr_ptr) + i) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wdata = '0;
    xfer           = 1'b0;
    if (state_q == GRANT) begin
      bus.req_ready[grant_id] = !bus.fifo_wfull;
      bus.fifo_wdata          = bus.req_data[int'(grant_id)*WIDTH +: WIDTH];
      xfer                    = bus.req_valid[grant_id] && !bus.fifo_wfull;
    end
    bus.fifo_wpush = xfer;
    release_grant  = xfer && (bus.req_last[grant_id] || (beat_cnt == CW'(MAX_BURST - 1)));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_id;
    gv_d    = grant_valid;
    rr_d    = rr_ptr;
    beat_d  = beat_cnt;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          gv_d    = 1'b1;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_d = beat_cnt + 1'b1;
        end
        if (release_grant) begin
          state_d = IDLE;
          gv_d    = 1'b0;
          rr_d    = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr      <= rr_d;
      grant_id    <= grant_d;
      grant_valid <= gv_d;
      beat_cnt    <= beat_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       grant_valid;
  logic [1:0] grant_id;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_push   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   push_cyc[$];
  // Producer beat queues: bit 17 = idle slot (valid low), bit 16 = last, 15:0 = data.
  logic [17:0] pq[N][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_beat(input int id, input logic [15:0] d, input bit last);
    pq[id].push_back({1'b0, last, d});
  endtask

  task automatic add_gap(input int id);
    pq[id].push_back(18'h20000);
  endtask

  task automatic expect_push(input int id, input logic [15:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic bit all_idle();
    bit r = 1'b1;
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_done(input string tag);
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0 && all_idle() && !grant_valid) break;
    end
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_grant"}, {31'd0, grant_valid}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Producer driver: accept sampled mid-cycle, queues advance just after the edge.
  initial begin
    logic [N-1:0]   acc;
    logic [N-1:0]   v, l;
    logic [N*W-1:0] d;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    d = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() > 0 && (pq[i][0][17] || acc[i])) void'(pq[i].pop_front());
        if (pq[i].size() > 0 && !pq[i][0][17]) begin
          v[i] = 1'b1;
          l[i] = pq[i][0][16];
          d[i*W +: W] = pq[i][0][15:0];
        end else begin
          v[i] = 1'b0;
          l[i] = 1'b0;
        end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.fifo_wfull) check("push_while_full", {31'd0, bus.fifo_wpush}, 0);
    if (rst_n && bus.fifo_wpush) begin
      exp_t e;
      n_push++;
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_push", {16'd0, bus.fifo_wdata}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("push_data", {16'd0, bus.fifo_wdata}, {16'd0, e.data});
        check("push_id", {30'd0, grant_id}, e.id);
      end
    end
  end

  initial begin
    int base;
    int gaps;
    rst_n = 1'b0;
    bus.fifo_wfull = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_grant_valid", {31'd0, grant_valid}, 0);
    check("rst_grant_id", {30'd0, grant_id}, 0);
    check("rst_wpush", {31'd0, bus.fifo_wpush}, 0);
    check("rst_ready", {28'd0, bus.req_ready}, 0);
    check("rst_wdata", {16'd0, bus.fifo_wdata}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    check("post_rst_grant_valid", {31'd0, grant_valid}, 0);

    // Single producer, 3-beat packet.
    push_cyc.delete();
    add_beat(2, 16'h00A1, 1'b0);
    add_beat(2, 16'h00A2, 1'b0);
    add_beat(2, 16'h00A3, 1'b1);
    expect_push(2, 16'h00A1);
    expect_push(2, 16'h00A2);
    expect_push(2, 16'h00A3);
    @(posedge clk);
    #3;
    check("t1_no_grant_yet", {31'd0, grant_valid}, 0);
    @(posedge clk);
    #3;
    check("t1_grant_valid", {31'd0, grant_valid}, 1);
    check("t1_grant_id", {30'd0, grant_id}, 2);
    repeat (3) @(posedge clk);
    #3;
    check("t1_release", {31'd0, grant_valid}, 0);
    check("t1_rr_ptr", {30'd0, dut.rr_ptr}, 3);
    check("t1_pushes", push_cyc.size(), 3);
    check("t1_back_to_back_a", push_cyc[1] - push_cyc[0], 1);
    check("t1_back_to_back_b", push_cyc[2] - push_cyc[1], 1);
    wait_done("t1");

    // All producers, 1-beat packets, from reset.
    @(posedge clk);
    #3;
    do_reset();
    push_cyc.delete();
    for (int i = 0; i < N; i++) add_beat(i, 16'h00B0 + 16'(i), 1'b1);
    add_beat(0, 16'h00B4, 1'b1);
    for (int i = 0; i < N; i++) expect_push(i, 16'h00B0 + 16'(i));
    expect_push(0, 16'h00B4);
    wait_done("t2");
    check("t2_pushes", push_cyc.size(), 5);
    for (int k = 0; k < 4; k++) check("t2_spacing", push_cyc[k+1] - push_cyc[k], 2);

    // Long packet capped at MAX_BURST with a waiting producer.
    do_reset();
    for (int b = 1; b <= 10; b++) add_beat(0, 16'h00C0 + 16'(b), b == 10);
    add_beat(1, 16'h00D1, 1'b1);
    for (int b = 1; b <= 4; b++) expect_push(0, 16'h00C0 + 16'(b));
    expect_push(1, 16'h00D1);
    for (int b = 5; b <= 10; b++) expect_push(0, 16'h00C0 + 16'(b));
    wait_done("t3");

    // FIFO full for 3 cycles mid-packet.
    base = n_push;
    for (int b = 1; b <= 5; b++) begin
      add_beat(3, 16'h00E0 + 16'(b), b == 5);
      expect_push(3, 16'h00E0 + 16'(b));
    end
    for (int t = 0; t < 50 && n_push < base + 2; t++) @(posedge clk);
    check("t4_reach_beat2", n_push - base, 2);
    #3;
    bus.fifo_wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_ready_low", {28'd0, bus.req_ready}, 0);
      check("t4_wpush_low", {31'd0, bus.fifo_wpush}, 0);
      check("t4_beat_cnt", {29'd0, dut.beat_cnt}, 2);
      check("t4_grant_held", {31'd0, grant_valid}, 1);
      @(posedge clk);
    end
    #3;
    bus.fifo_wfull = 1'b0;
    wait_done("t4");

    // Granted producer drops valid for 2 cycles.
    base = n_push;
    gaps = 0;
    add_beat(1, 16'h00F1, 1'b0);
    add_beat(1, 16'h00F2, 1'b0);
    add_gap(1);
    add_gap(1);
    add_beat(1, 16'h00F3, 1'b0);
    add_beat(1, 16'h00F4, 1'b1);
    for (int b = 1; b <= 4; b++) expect_push(1, 16'h00F0 + 16'(b));
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (n_push >= base + 4) break;
      if (n_push >= base + 1 && !bus.req_valid[1]) begin
        check("t5_grant_held", {31'd0, grant_valid}, 1);
        check("t5_grant_id", {30'd0, grant_id}, 1);
        check("t5_no_push", {31'd0, bus.fifo_wpush}, 0);
        gaps++;
      end
    end
    check("t5_gap_cycles", gaps, 2);
    wait_done("t5");

    // Reset during beat 2; first post-reset grant goes to the lowest valid index.
    base = n_push;
    for (int b = 1; b <= 4; b++) add_beat(3, 16'h0100 + 16'(b), b == 4);
    add_beat(1, 16'h0201, 1'b1);
    expect_push(3, 16'h0101);
    expect_push(1, 16'h0201);
    for (int b = 2; b <= 4; b++) expect_push(3, 16'h0100 + 16'(b));
    for (int t = 0; t < 50 && n_push < base + 1; t++) @(posedge clk);
    check("t6_reach_beat1", n_push - base, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_wpush_cleared", {31'd0, bus.fifo_wpush}, 0);
    check("t6_grant_cleared", {31'd0, grant_valid}, 0);
    check("t6_id_cleared", {30'd0, grant_id}, 0);
    check("t6_ready_cleared", {28'd0, bus.req_ready}, 0);
    check("t6_wdata_cleared", {16'd0, bus.fifo_wdata}, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int t = 0; t < 20 && !grant_valid; t++) begin
      @(posedge clk);
      #3;
    end
    check("t6_first_grant_valid", {31'd0, grant_valid}, 1);
    check("t6_first_grant_id", {30'd0, grant_id}, 1);
    wait_done("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
